// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int          WAIT_W     = 8;
  localparam int          CNT_W      = 16;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = 8'd255;

  // Register 0 is hardwired to zero, so it never carries a real dependency.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: load-use stalls, branch/jump flushes,
// data-memory wait holding with a timeout, plus stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic             mem_busy,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_flush,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  hz_state_e         state;
  logic              pend_branch;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              load_use;

  assign load_use  = load_use_hit(ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt);
  assign wait_next = wait_cnt + 1'b1;

  // While reset is held the pipeline free-runs regardless of inputs.
  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_flush    = 1'b0;
    flush       = 1'b0;
    if (reset) begin
      unique case (state)
        ST_RUN: begin
          if (mem_busy) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
          end else if (branch_taken) begin
            IF_flush = 1'b1;
            flush    = 1'b1;
          end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            flush       = 1'b1;
          end else if (jump || jr) begin
            IF_flush = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (mem_busy) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
          end else begin
            IF_flush = 1'b1;
            flush    = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A branch interrupted by a memory hold is replayed as a FLUSH once memory is ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      pend_branch <= 1'b0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (mem_busy) begin
            state       <= ST_MEM_WAIT;
            pend_branch <= branch_taken;
            wait_cnt    <= '0;
          end else if (branch_taken) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (mem_busy) begin
            state       <= ST_MEM_WAIT;
            pend_branch <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_busy) begin
            state       <= pend_branch ? ST_FLUSH : ST_RUN;
            pend_branch <= 1'b0;
            wait_cnt    <= '0;
          end else if (wait_next == WAIT_LIMIT) begin
            state       <= ST_RUN;
            pend_branch <= 1'b0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        default: begin
          state       <= ST_RUN;
          pend_branch <= 1'b0;
          wait_cnt    <= '0;
        end
      endcase
    end
  end

  sat_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~PCWrite),
    .count (stall_count)
  );

  sat_counter u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush | IF_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ID_EX_MemRead = 1'b0;
  logic [4:0]  ID_EX_Rt = '0;
  logic [4:0]  IF_ID_Rs = '0;
  logic [4:0]  IF_ID_Rt = '0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        jr = 1'b0;
  logic        mem_busy = 1'b0;
  logic        PCWrite, IF_ID_Write, IF_flush, flush, mem_timeout;
  logic [15:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory-wait length, pending branch replay, flush-in-progress.
  bit m_waiting, m_flushing, m_pend, m_timeout;
  int m_waited, m_stalls, m_flushes;
  int first_timeout;

  hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .jr            (jr),
    .mem_busy      (mem_busy),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .IF_flush      (IF_flush),
    .flush         (flush),
    .stall_count   (stall_count),
    .flush_count   (flush_count),
    .mem_timeout   (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_waiting  = 0;
    m_flushing = 0;
    m_pend     = 0;
    m_timeout  = 0;
    m_waited   = 0;
    m_stalls   = 0;
    m_flushes  = 0;
  endtask

  task automatic doReset();
    reset         = 1'b0;
    mem_busy      = 1'b1;
    ID_EX_MemRead = 1'b1;
    ID_EX_Rt      = 5'd3;
    IF_ID_Rs      = 5'd3;
    #1;
    checkOutput("rst_PCWrite", PCWrite, 1);
    checkOutput("rst_IF_ID_Write", IF_ID_Write, 1);
    checkOutput("rst_IF_flush", IF_flush, 0);
    checkOutput("rst_flush", flush, 0);
    checkOutput("rst_stall_count", stall_count, 0);
    checkOutput("rst_flush_count", flush_count, 0);
    checkOutput("rst_mem_timeout", mem_timeout, 0);
    @(posedge clk);
    #1;
    mem_busy      = 1'b0;
    ID_EX_MemRead = 1'b0;
    ID_EX_Rt      = '0;
    IF_ID_Rs      = '0;
    reset         = 1'b1;
    modelReset();
  endtask

  // Drives one cycle of inputs, checks outputs/counters mid-cycle, then advances the model.
  task automatic applyStimulus(input bit mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                               input logic [4:0] rt, input bit br, input bit j,
                               input bit jrr, input bit busy);
    bit lu, e_pc, e_ifid, e_iff, e_fl;
    ID_EX_MemRead = mr;
    ID_EX_Rt      = ex_rt;
    IF_ID_Rs      = rs;
    IF_ID_Rt      = rt;
    branch_taken  = br;
    jump          = j;
    jr            = jrr;
    mem_busy      = busy;
    #3;
    lu     = mr && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
    e_pc   = 1;
    e_ifid = 1;
    e_iff  = 0;
    e_fl   = 0;
    if (m_waiting) begin
      e_pc   = 0;
      e_ifid = 0;
    end else if (busy) begin
      e_pc   = 0;
      e_ifid = 0;
    end else if (m_flushing || br) begin
      e_iff = 1;
      e_fl  = 1;
    end else if (lu) begin
      e_pc   = 0;
      e_ifid = 0;
      e_fl   = 1;
    end else if (j || jrr) begin
      e_iff = 1;
    end
    checkOutput("PCWrite", PCWrite, e_pc);
    checkOutput("IF_ID_Write", IF_ID_Write, e_ifid);
    checkOutput("IF_flush", IF_flush, e_iff);
    checkOutput("flush", flush, e_fl);
    checkOutput("stall_count", stall_count, m_stalls);
    checkOutput("flush_count", flush_count, m_flushes);
    checkOutput("mem_timeout", mem_timeout, m_timeout);
    if (m_waiting) begin
      if (!busy) begin
        m_waiting  = 0;
        m_flushing = m_pend;
        m_pend     = 0;
        m_waited   = 0;
      end else if (m_waited + 1 == 255) begin
        m_waiting = 0;
        m_timeout = 1;
        m_pend    = 0;
        m_waited  = 0;
      end else begin
        m_waited++;
      end
    end else if (busy) begin
      m_waiting  = 1;
      m_pend     = m_flushing || br;
      m_flushing = 0;
      m_waited   = 0;
    end else if (m_flushing) begin
      m_flushing = 0;
    end else if (br) begin
      m_flushing = 1;
    end
    if (!e_pc) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    if (e_iff || e_fl) m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    doReset();

    // Load to $5 with ID reading $5: single stall.
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("loaduse_stall_count", stall_count, 1);

    // $0 never stalls.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("reg0_stall_count", stall_count, 0);

    // Single-cycle taken branch flushes two cycles.
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    checkOutput("branch_flush_count", flush_count, 2);

    // Jump and jr flush IF only.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 7, 0, 7, 0, 1, 0, 0);

    // Memory hold with a simultaneous branch, replayed as FLUSH afterwards.
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    checkOutput("memwait_stall_count", stall_count, 4);
    checkOutput("memwait_flush_count", flush_count, 1);

    // Memory-wait timeout.
    doReset();
    first_timeout = -1;
    for (int i = 0; i < 300; i++) begin
      if (first_timeout < 0 && mem_timeout === 1'b1) first_timeout = i;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("timeout_cycle", first_timeout, 256);
    reset = 1'b0;
    #1;
    checkOutput("timeout_reset_clear", mem_timeout, 0);
    doReset();

    // Random traffic with small register numbers so matches are common.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 499) == 0) doReset();
    end

    // Sustained load-use stalls drive both counters into saturation.
    doReset();
    for (int i = 0; i < 65540; i++) applyStimulus(1, 9, 9, 9, 0, 0, 0, 0);
    idle(1);
    checkOutput("sat_stall_count", stall_count, 16'hFFFF);
    checkOutput("sat_flush_count", flush_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
